// File: rtl/ascii_stream_mapper_pkg.sv
// Shared types and constants for the luminance-to-ASCII mapper:
// default brightness ramp, character type and 2x2 ordered-dither matrix.
package ascii_pkg;

    typedef logic [7:0] char_t;

    localparam int unsigned RAMP_LEN = 48;

    // Standard brightness ramp, index 0 (darkest, ' ') .. 47 (brightest, 'Q').
    // Concatenation lists entry 47 first so that [i] selects entry i.
    localparam logic [RAMP_LEN-1:0][7:0] ASCII_RAMP_DEFAULT = {
        8'h51, 8'h4D, 8'h57, 8'h4F, 8'h6D, 8'h77, 8'h71, 8'h70,  // 47..40 QMWOmwqp
        8'h64, 8'h62, 8'h68, 8'h6B, 8'h55, 8'h5A, 8'h58, 8'h59,  // 39..32 dbhkUZXY
        8'h43, 8'h4C, 8'h74, 8'h66, 8'h4A, 8'h73, 8'h61, 8'h65,  // 31..24 CLtfJsae
        8'h6F, 8'h75, 8'h6E, 8'h78, 8'h7A, 8'h76, 8'h6C, 8'h69,  // 23..16 ounxzvli
        8'h3E, 8'h3C, 8'h2B, 8'h2F, 8'h63, 8'h72, 8'h21, 8'h3B,  // 15..8  ><+/cr!;
        8'h7E, 8'h5F, 8'h2D, 8'h3A, 8'h2C, 8'h60, 8'h2E, 8'h20   // 7..0   ~_-:,`.sp
    };

    // Bayer 2x2 values indexed by {py, px}: {0, 2, 3, 1}.
    localparam logic [3:0][1:0] BAYER2 = {2'd1, 2'd3, 2'd2, 2'd0};

    // Default table content for entry idx; entries past the ramp are blanks.
    function automatic char_t ramp_default(input int unsigned idx);
        logic [5:0] sel;
        sel = idx[5:0];
        if (idx < RAMP_LEN) begin
            return ASCII_RAMP_DEFAULT[sel];
        end
        return 8'h20;
    endfunction

endpackage

// File: rtl/ascii_stream_mapper_if.sv
// Valid/ready stream bundle: luma beats in, character beats out.
interface ascii_stream_mapper_if #(
    parameter int unsigned LUMA_W = 8,
    parameter int unsigned CHAR_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [LUMA_W-1:0] s_luma;
    logic              s_sof;
    logic              s_eol;
    logic              m_valid;
    logic              m_ready;
    logic [CHAR_W-1:0] m_char;
    logic              m_sof;
    logic              m_eol;

    modport master (
        output s_valid, s_luma, s_sof, s_eol, m_ready,
        input  s_ready, m_valid, m_char, m_sof, m_eol
    );

    modport slave (
        input  s_valid, s_luma, s_sof, s_eol, m_ready,
        output s_ready, m_valid, m_char, m_sof, m_eol
    );
endinterface

// File: rtl/ascii_glyph_table.sv
// Run-time writable glyph table: async reset to the default ramp,
// one write port, one registered read port (read-before-write).
module ascii_glyph_table
    import ascii_pkg::*;
#(
    parameter int unsigned LEVELS = 48,
    parameter int unsigned CHAR_W = 8,
    parameter int unsigned ID_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ID_W-1:0]   waddr_i,
    input  logic [CHAR_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ID_W-1:0]   raddr_i,
    output logic [CHAR_W-1:0] rdata_o
);

    logic [CHAR_W-1:0] mem_q [LEVELS];
    logic [CHAR_W-1:0] rdata_q;

    // Table storage; out-of-range write addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LEVELS; i++) begin
                mem_q[i] <= CHAR_W'(ramp_default(i));
            end
        end else if (we_i && ({1'b0, waddr_i} < (ID_W+1)'(LEVELS))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; a same-cycle write to the same entry is seen next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ascii_stream_mapper.sv
// Streaming luminance-to-ASCII mapper, two pipeline stages (scale, lookup),
// one beat per cycle with a global stall. Build option ASCII_DITHER_EN adds
// 2x2 ordered dithering ahead of the inversion step.
module ascii_stream_mapper
    import ascii_pkg::*;
#(
    parameter  int unsigned LUMA_W = 8,
    parameter  int unsigned LEVELS = 48,
    parameter  int unsigned CHAR_W = 8,
    localparam int unsigned ID_W   = $clog2(LEVELS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ascii_stream_mapper_if.slave bus,
    input  logic                 invert,
    input  logic                 tbl_we,
    input  logic [ID_W-1:0]      tbl_addr,
    input  logic [CHAR_W-1:0]    tbl_data
);

    localparam int unsigned     PROD_W = LUMA_W + ID_W + 1;
    localparam logic [ID_W-1:0] ID_MAX = ID_W'(LEVELS - 1);

    logic              ce;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] dither_add;
    logic [ID_W:0]     idx_raw;
    logic [ID_W-1:0]   id_sat;
    logic [ID_W-1:0]   id_c;

    logic              s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]   s1_id_q,    s1_id_d;
    logic              s1_sof_q,   s1_sof_d;
    logic              s1_eol_q,   s1_eol_d;
    logic              m_valid_q,  m_valid_d;
    logic              m_sof_q,    m_sof_d;
    logic              m_eol_q,    m_eol_d;
    logic [CHAR_W-1:0] tbl_rdata;

    assign ce = !m_valid_q || bus.m_ready;

`ifdef ASCII_DITHER_EN
    logic       px_q, px_d;
    logic       py_q, py_d;
    logic       px_eff, py_eff;
    logic [1:0] bayer;

    // Dither offset and frame/line parity tracking; an sof beat restarts at (0,0).
    always_comb begin
        px_eff     = bus.s_sof ? 1'b0 : px_q;
        py_eff     = bus.s_sof ? 1'b0 : py_q;
        bayer      = BAYER2[{py_eff, px_eff}];
        dither_add = PROD_W'(bayer) << (LUMA_W - 2);
        px_d       = px_q;
        py_d       = py_q;
        if (bus.s_valid && ce) begin
            if (bus.s_eol) begin
                px_d = 1'b0;
                py_d = !py_eff;
            end else begin
                px_d = !px_eff;
                py_d = py_eff;
            end
        end
    end

    // Parity registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q <= 1'b0;
            py_q <= 1'b0;
        end else begin
            px_q <= px_d;
            py_q <= py_d;
        end
    end
`else
    assign dither_add = '0;
`endif

    // Scale luma to a saturated glyph index, then optionally invert it.
    always_comb begin
        prod    = PROD_W'(bus.s_luma) * PROD_W'(LEVELS) + dither_add;
        idx_raw = (ID_W+1)'(prod >> LUMA_W);
        id_sat  = (idx_raw > {1'b0, ID_MAX}) ? ID_MAX : idx_raw[ID_W-1:0];
        id_c    = invert ? (ID_MAX - id_sat) : id_sat;
    end

    // Next state of both pipeline stages; everything holds when stalled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_sof_d   = s1_sof_q;
        s1_eol_d   = s1_eol_q;
        m_valid_d  = m_valid_q;
        m_sof_d    = m_sof_q;
        m_eol_d    = m_eol_q;
        if (ce) begin
            s1_valid_d = bus.s_valid;
            s1_id_d    = id_c;
            s1_sof_d   = bus.s_sof;
            s1_eol_d   = bus.s_eol;
            m_valid_d  = s1_valid_q;
            m_sof_d    = s1_sof_q;
            m_eol_d    = s1_eol_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_sof_q    <= 1'b0;
            m_eol_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_sof_q   <= s1_sof_d;
            s1_eol_q   <= s1_eol_d;
            m_valid_q  <= m_valid_d;
            m_sof_q    <= m_sof_d;
            m_eol_q    <= m_eol_d;
        end
    end

    // Stage-2 lookup: the table's read register is the m_char register.
    ascii_glyph_table #(
        .LEVELS (LEVELS),
        .CHAR_W (CHAR_W),
        .ID_W   (ID_W)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (tbl_we),
        .waddr_i (tbl_addr),
        .wdata_i (tbl_data),
        .re_i    (ce),
        .raddr_i (s1_id_q),
        .rdata_o (tbl_rdata)
    );

    assign bus.s_ready = ce;
    assign bus.m_valid = m_valid_q;
    assign bus.m_char  = tbl_rdata;
    assign bus.m_sof   = m_sof_q;
    assign bus.m_eol   = m_eol_q;

endmodule

// File: tb/tb_ascii_stream_mapper.sv
// Directed bench for ascii_stream_mapper: reset, mapping, inversion,
// back-pressure, table writes, mid-stream reset and the dither option.
module tb_ascii_stream_mapper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       invert;
    logic       tbl_we;
    logic [5:0] tbl_addr;
    logic [7:0] tbl_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Beat tables for run_stream
    logic [7:0] luma_v [8];
    logic       inv_v  [8];
    logic       sof_v  [8];
    logic       eol_v  [8];
    logic [7:0] exp_v  [8];

    always #5 clk = ~clk;

    ascii_stream_mapper_if #(.LUMA_W(8), .CHAR_W(8)) bus ();

    ascii_stream_mapper #(
        .LUMA_W (8),
        .LEVELS (48),
        .CHAR_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .invert   (invert),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] luma, input logic inv,
                         input logic sof, input logic eol);
        bus.s_valid = v;
        bus.s_luma  = luma;
        bus.s_sof   = sof;
        bus.s_eol   = eol;
        invert      = inv;
    endtask

    task automatic idle();
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_beat(input int i, input logic [7:0] luma, input logic inv,
                            input logic sof, input logic eol, input logic [7:0] exp);
        luma_v[i] = luma;
        inv_v[i]  = inv;
        sof_v[i]  = sof;
        eol_v[i]  = eol;
        exp_v[i]  = exp;
    endtask

    // Streams n beats with m_ready=1 from an empty pipe; outputs due two cycles later.
    task automatic run_stream(input int n, input string tag);
        bus.m_ready = 1'b1;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check($sformatf("%s_valid%0d", tag, i - 2), 32'(bus.m_valid), 32'd1);
                check($sformatf("%s_char%0d", tag, i - 2), 32'(bus.m_char), 32'(exp_v[i-2]));
                check($sformatf("%s_sof%0d", tag, i - 2), 32'(bus.m_sof), 32'(sof_v[i-2]));
                check($sformatf("%s_eol%0d", tag, i - 2), 32'(bus.m_eol), 32'(eol_v[i-2]));
            end
            if (i < n) drive(1'b1, luma_v[i], inv_v[i], sof_v[i], eol_v[i]);
            else       idle();
        end
        @(negedge clk);
        check($sformatf("%s_drain", tag), 32'(bus.m_valid), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        tbl_we      = 1'b0;
        tbl_addr    = '0;
        tbl_data    = '0;
        bus.m_ready = 1'b1;
        idle();

        // Reset state
        @(negedge clk);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_char", 32'(bus.m_char), 32'd0);
        check("rst_m_sof", 32'(bus.m_sof), 32'd0);
        check("rst_m_eol", 32'(bus.m_eol), 32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic ramp: 0 -> ' ', 128 -> id 24 'e', 255 -> id 47 'Q'
        set_beat(0, 8'd0,   1'b0, 1'b1, 1'b0, 8'h20);
        set_beat(1, 8'd128, 1'b0, 1'b0, 1'b0, 8'h65);
        set_beat(2, 8'd255, 1'b0, 1'b0, 1'b1, 8'h51);
        run_stream(3, "basic");

        // Inversion, including per-beat toggling
        set_beat(0, 8'd0,   1'b1, 1'b0, 1'b0, 8'h51);
        set_beat(1, 8'd255, 1'b1, 1'b0, 1'b0, 8'h20);
        set_beat(2, 8'd0,   1'b0, 1'b0, 1'b0, 8'h20);
        set_beat(3, 8'd0,   1'b1, 1'b0, 1'b0, 8'h51);
        set_beat(4, 8'd128, 1'b1, 1'b0, 1'b1, 8'h4A);  // 47-24 = 23? see below
        exp_v[4] = 8'h6F;                               // id 23 = 'o'
        run_stream(5, "inv");

        // Back-pressure: three beats offered while m_ready=0
        bus.m_ready = 1'b0;
        @(negedge clk);
        check("stall_ready0", 32'(bus.s_ready), 32'd1);
        drive(1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("stall_ready1", 32'(bus.s_ready), 32'd1);
        drive(1'b1, 8'd128, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'd255, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stall_sready%0d", k), 32'(bus.s_ready), 32'd0);
            check($sformatf("stall_valid%0d", k), 32'(bus.m_valid), 32'd1);
            check($sformatf("stall_char%0d", k), 32'(bus.m_char), 32'h20);
            check($sformatf("stall_sof%0d", k), 32'(bus.m_sof), 32'd1);
            @(negedge clk);
        end
        check("stall_sready4", 32'(bus.s_ready), 32'd0);
        bus.m_ready = 1'b1;
        @(negedge clk);
        idle();
        check("rel_char1", 32'(bus.m_char), 32'h65);
        check("rel_valid1", 32'(bus.m_valid), 32'd1);
        @(negedge clk);
        check("rel_char2", 32'(bus.m_char), 32'h51);
        check("rel_eol2", 32'(bus.m_eol), 32'd1);
        @(negedge clk);
        check("rel_drain", 32'(bus.m_valid), 32'd0);

        // Table write racing a stage-2 read of the same entry
        drive(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        tbl_we   = 1'b1;
        tbl_addr = 6'd47;
        tbl_data = 8'h23;
        @(negedge clk);
        tbl_we = 1'b0;
        idle();
        check("wr_old", 32'(bus.m_char), 32'h51);
        @(negedge clk);
        check("wr_new", 32'(bus.m_char), 32'h23);
        // Out-of-range address must be ignored
        tbl_we   = 1'b1;
        tbl_addr = 6'd50;
        tbl_data = 8'h41;
        @(negedge clk);
        tbl_we = 1'b0;
        set_beat(0, 8'd255, 1'b0, 1'b0, 1'b0, 8'h23);
        set_beat(1, 8'd0,   1'b0, 1'b0, 1'b0, 8'h20);
        set_beat(2, 8'd200, 1'b0, 1'b0, 1'b1, 8'h68);
        run_stream(3, "oob");

        // Reset with two beats in flight
        drive(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_pre_valid", 32'(bus.m_valid), 32'd1);
        idle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_post_valid0", 32'(bus.m_valid), 32'd0);
        @(negedge clk);
        check("mid_post_valid1", 32'(bus.m_valid), 32'd0);
        set_beat(0, 8'd255, 1'b0, 1'b1, 1'b0, 8'h51);
        run_stream(1, "mid_tbl");

        // Dither pattern: (0,0) b0, (1,0) b2, (0,0) b0 eol, (0,1) b3, (1,1) b1
`ifdef ASCII_DITHER_EN
        set_beat(0, 8'd255, 1'b0, 1'b1, 1'b0, 8'h51);
        set_beat(1, 8'd250, 1'b0, 1'b0, 1'b0, 8'h51);
        set_beat(2, 8'd200, 1'b0, 1'b0, 1'b1, 8'h68);
        set_beat(3, 8'd255, 1'b0, 1'b0, 1'b0, 8'h51);
        set_beat(4, 8'd250, 1'b0, 1'b0, 1'b0, 8'h51);
`else
        set_beat(0, 8'd255, 1'b0, 1'b1, 1'b0, 8'h51);
        set_beat(1, 8'd250, 1'b0, 1'b0, 1'b0, 8'h4D);
        set_beat(2, 8'd200, 1'b0, 1'b0, 1'b1, 8'h68);
        set_beat(3, 8'd255, 1'b0, 1'b0, 1'b0, 8'h51);
        set_beat(4, 8'd250, 1'b0, 1'b0, 1'b0, 8'h4D);
`endif
        run_stream(5, "dith");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ascii_stream_mapper.md
Name: ascii_stream_mapper

Overview:
- Streaming luminance-to-ASCII converter: accepts one pixel luminance per beat over valid/ready and emits one character code per beat over valid/ready.
- Scales luma to a glyph index with parametrised level count, applies optional inversion, and looks the index up in a run-time-writable glyph table.
- Sits between the downscaled-luma stage and the text framebuffer/UART writer.
- Fully pipelined: 1 beat/cycle throughput, back-pressure honoured.

Parameters:
- LUMA_W, 8, input luminance width in bits.
- LEVELS, 48, number of glyph levels (table depth), 2..64.
- CHAR_W, 8, output character width.
- ID_W, $clog2(LEVELS), index width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&&s_ready.
- s_luma  in  LUMA_W  pixel luminance.
- s_sof  in  1  first pixel of frame.
- s_eol  in  1  last pixel of line.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_char  out  CHAR_W  character code.
- m_sof  out  1  s_sof delayed with its beat.
- m_eol  out  1  s_eol delayed with its beat.
- invert  in  1  1 = dark-on-light mapping, sampled per beat at acceptance.
- tbl_we  in  1  glyph table write strobe.
- tbl_addr  in  ID_W  table write address.
- tbl_data  in  CHAR_W  table write data.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values:
  - m_valid=0, m_char=0, m_sof=0, m_eol=0.
  - All internal stage valids = 0.
  - Table loaded with package default ramp; with LEVELS<48, first LEVELS entries; beyond 48, entries = 0x20.
- Pipeline: 2 stages.
  - Global advance ce = !m_valid || m_ready; s_ready = ce.
  - Latency: an accepted beat appears on m_* exactly 2 ce-cycles later.
  - A stalled beat holds m_char/m_sof/m_eol stable while m_valid=1 && !m_ready.
- Stage 1 (scale):
  - prod = s_luma*LEVELS, width LUMA_W+ID_W+1.
  - id = prod >> LUMA_W, saturated to LEVELS-1.
  - If invert, id = LEVELS-1-id.
  - Registers id, sof, eol, valid.
- Stage 2 (lookup): m_char <= table[id], registered; sof/eol/valid forwarded.
- Table writes:
  - Writes take effect at the clock edge regardless of ce or stall.
  - tbl_addr >= LEVELS ignored.
  - A write and a stage-2 read of the same address in the same cycle: the read returns the old value; the new value is seen from the next cycle.
- Bubbles: s_valid=0 while ce=1 inserts a bubble; stage valids are cleared, data is don't-care.
- Reset mid-stream: in-flight beats are discarded; no partial output; the table reverts to default.
- Back-to-back streaming with m_ready=1: one output per cycle, no gaps.

Optional Feature:
- Macro ASCII_DITHER_EN.
- Defined:
  - 2x2 ordered dither.
  - Parity counters px, py:
    - px toggles per accepted beat; cleared after an eol beat.
    - py toggles after each eol beat.
    - Both forced to 0 on an sof beat (that beat uses px=py=0).
  - Bayer value b = {0,2,3,1}[{py,px}].
  - prod = s_luma*LEVELS + b*(2^LUMA_W/4), then shift and saturate as above.
  - Dither applies before inversion.
- Undefined: b=0, no parity counters; output bit-identical to the undithered path.

Decomposition:
- Package ascii_pkg holds:
  - ASCII_RAMP_DEFAULT: 48x8 constant, index 0=' ' through 47='Q', the team's standard brightness ramp.
  - char_t typedef (8-bit).
  - BAYER2 constant.
- Sub-module ascii_glyph_table: LEVELS-deep register file with async reset to default, one write port, one registered read port.
- Scale/dither/pipeline control stays in the top module.

Test Plan:
- Reset, then stream luma 0,128,255 with m_ready=1 -> m_char 0x20,0x65('e'),0x51('Q') on cycles 2,3,4 after first acceptance; sof/eol aligned.
- invert=1, luma 0 then 255 -> 0x51 then 0x20; toggle invert mid-stream -> mapping changes exactly on the beat accepted with the new value.
- Hold m_ready=0 for 5 cycles with 3 beats offered -> s_ready drops once the pipe is full, no beat lost or duplicated, m_char stable while stalled, order preserved on release.
- tbl_we addr=47 data=0x23 while a luma-255 beat is at stage 2 in the same cycle -> that beat outputs 0x51, the next luma-255 beat outputs 0x23; addr=50 write ignored.
- Assert rst_n low with 2 beats in flight -> m_valid=0 immediately, no stray output after release, addr 47 reads 0x51 again.
- ASCII_DITHER_EN: sof beat luma 255 -> b=0 -> 0x51; second pixel luma 250 (b=2, prod 12128) -> id 47 -> 0x51; luma 255 at b=3 saturates to 47; without macro, luma 250 -> id 46 -> 'M'.
